// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I load/store path.
// Holds the LSU state encoding, funct3 codes and the legality check.
package riscv_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int REG_ADDR_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        WB
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] gives the access size for both signed and unsigned loads
    function automatic logic op_fault(
        input logic       is_store,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic bad_f3;
        logic misal;
        bad_f3 = is_store ? (f3 > F3_W)
                          : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        misal  = ((f3[1:0] == 2'b01) && off[0]) ||
                 ((f3[1:0] == 2'b10) && (off != 2'b00));
        return bad_f3 || misal;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data memory bus between the load/store unit and memory.
// Request channel uses valid/ready; read data returns with rsp_valid.
interface load_store_unit_if
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = DATA_WIDTH
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [3:0]            mem_wstrb;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_addr,
        output mem_we,
        output mem_wstrb,
        output mem_wdata,
        input  mem_rsp_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_addr,
        input  mem_we,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_rsp_valid,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a read word and sign/zero extends it.
// Purely combinational; sits between memory read data and writeback.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] wb_data
);
    logic [DATA_WIDTH-1:0] lane;

    assign lane = mem_rdata >> {offset, 3'b000};

    always_comb begin
        wb_data = lane;
        unique case (funct3)
            F3_B:    wb_data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    wb_data = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   wb_data = {24'h0, lane[7:0]};
            F3_HU:   wb_data = {16'h0, lane[15:0]};
            default: wb_data = lane;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one op at a time, memory handshake,
// load alignment and a one-cycle register file writeback.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = DATA_WIDTH
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_is_store,
    input  logic [2:0]               req_funct3,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_store_data,
    input  logic [REG_ADDR_BITS-1:0] req_rd,
    load_store_unit_if.master        mem,
    output logic                     wb_enable,
    output logic [REG_ADDR_BITS-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     fault,
    output logic [ADDR_WIDTH-1:0]    fault_addr
);
    lsu_state_e state;

    logic                     op_store;
    logic [2:0]               op_funct3;
    logic [1:0]               op_offset;
    logic [REG_ADDR_BITS-1:0] op_rd;

    logic                  mreq_valid;
    logic [ADDR_WIDTH-1:0] maddr;
    logic                  mwe;
    logic [3:0]            mwstrb;
    logic [DATA_WIDTH-1:0] mwdata;

    logic [3:0]            st_wstrb;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  bad_op;

    assign mem.mem_req_valid = mreq_valid;
    assign mem.mem_addr      = maddr;
    assign mem.mem_we        = mwe;
    assign mem.mem_wstrb     = mwstrb;
    assign mem.mem_wdata     = mwdata;

    assign bad_op = op_fault(req_is_store, req_funct3, req_addr[1:0]);

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = req_store_data;
        unique case (req_funct3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_store_data[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << req_addr[1:0];
                st_wdata = {2{req_store_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = req_store_data;
            end
        endcase
    end

    lsu_load_align u_align (
        .mem_rdata (mem.mem_rdata),
        .offset    (op_offset),
        .funct3    (op_funct3),
        .wb_data   (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            op_store   <= 1'b0;
            op_funct3  <= 3'b000;
            op_offset  <= 2'b00;
            op_rd      <= '0;
            mreq_valid <= 1'b0;
            maddr      <= '0;
            mwe        <= 1'b0;
            mwstrb     <= 4'b0000;
            mwdata     <= '0;
            wb_enable  <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            fault     <= 1'b0;
            wb_enable <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            unique case (state)
                IDLE: begin
                    if (req_valid && bad_op) begin
                        fault      <= 1'b1;
                        fault_addr <= req_addr;
                    end else if (req_valid) begin
                        state      <= REQ;
                        req_ready  <= 1'b0;
                        op_store   <= req_is_store;
                        op_funct3  <= req_funct3;
                        op_offset  <= req_addr[1:0];
                        op_rd      <= req_rd;
                        mreq_valid <= 1'b1;
                        maddr      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mwe        <= req_is_store;
                        mwstrb     <= req_is_store ? st_wstrb : 4'b0000;
                        mwdata     <= req_is_store ? st_wdata : '0;
                    end
                end
                REQ: begin
                    if (mem.mem_req_ready) begin
                        mreq_valid <= 1'b0;
                        maddr      <= '0;
                        mwe        <= 1'b0;
                        mwstrb     <= 4'b0000;
                        mwdata     <= '0;
                        if (op_store) begin
                            state     <= IDLE;
                            req_ready <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        state     <= WB;
                        wb_enable <= (op_rd != '0);
                        wb_addr   <= op_rd;
                        wb_data   <= ld_data;
                    end
                end
                WB: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: scoreboarded memory requests and
// writebacks, faults, stalls and reset in the middle of a load.
module tb_load_store_unit;
    import riscv_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_store_data;
    logic [4:0]  req_rd;
    logic        wb_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fault;
    logic [31:0] fault_addr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_exp_t exp_mem_q[$];
    wb_exp_t  exp_wb_q[$];

    load_store_unit_if #(.ADDR_WIDTH(32)) mem_bus ();

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_store_data (req_store_data),
        .req_rd         (req_rd),
        .mem            (mem_bus),
        .wb_enable      (wb_enable),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .fault          (fault),
        .fault_addr     (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic mem_exp_t cur_mem();
        return {mem_bus.mem_addr, mem_bus.mem_we,
                mem_bus.mem_wstrb, mem_bus.mem_wdata};
    endfunction

    // Drive one op for one clock; returns at the negedge after accept.
    task automatic send(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd);
        @(negedge clk);
        req_valid      = 1'b1;
        req_is_store   = st;
        req_funct3     = f3;
        req_addr       = a;
        req_store_data = d;
        req_rd         = rd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for a request, capture it and grant it for one edge.
    task automatic serve_mem(output mem_exp_t got, output int waited);
        waited = 0;
        while (!mem_bus.mem_req_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        got = cur_mem();
        mem_bus.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_bus.mem_req_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [141:0] obs;
        logic [141:0] exp;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        obs = {req_ready, mem_bus.mem_req_valid, mem_bus.mem_addr,
               mem_bus.mem_we, mem_bus.mem_wstrb, mem_bus.mem_wdata,
               wb_enable, wb_addr, wb_data, fault, fault_addr};
        exp = {1'b1, 141'h0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs, exp);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sw();
        mem_exp_t got, e;
        int w;
        exp_mem_q.push_back({32'h100, 1'b1, 4'b1111, 32'hDEADBEEF});
        send(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 5'd0);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_busy: req_ready %b want 0", req_ready);
        end
        serve_mem(got, w);
        e = exp_mem_q.pop_front();
        n_checks++;
        if (w !== 0 || got !== e) begin
            n_fail++;
            $display("FAIL sw_req: got %h wait %0d want %h wait 0", got, w, e);
        end
        n_checks++;
        if ({req_ready, wb_enable, mem_bus.mem_req_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL sw_done: rdy/wb/mv %b%b%b want 100",
                     req_ready, wb_enable, mem_bus.mem_req_valid);
        end
    endtask

    task automatic test_sub_word_stores();
        mem_exp_t got, e;
        int w;
        exp_mem_q.push_back({32'h200, 1'b1, 4'b1000, 32'hA5A5A5A5});
        send(1'b1, F3_B, 32'h203, 32'h000000A5, 5'd0);
        serve_mem(got, w);
        e = exp_mem_q.pop_front();
        n_checks++;
        if (w !== 0 || got !== e) begin
            n_fail++;
            $display("FAIL sb_req: got %h want %h", got, e);
        end
        exp_mem_q.push_back({32'h204, 1'b1, 4'b1100, 32'h56785678});
        send(1'b1, F3_H, 32'h206, 32'h12345678, 5'd0);
        serve_mem(got, w);
        e = exp_mem_q.pop_front();
        n_checks++;
        if (w !== 0 || got !== e) begin
            n_fail++;
            $display("FAIL sh_req: got %h want %h", got, e);
        end
    endtask

    task automatic test_loads();
        ld_vec_t  v;
        mem_exp_t got, e;
        wb_exp_t  we, wo;
        int w;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: v = {F3_B,  32'h103, 5'd5,  32'h80FF1234, 32'hFFFFFF80};
                1: v = {F3_HU, 32'h102, 5'd7,  32'h80FF1234, 32'h000080FF};
                2: v = {F3_H,  32'h102, 5'd7,  32'h80FF1234, 32'hFFFF80FF};
                3: v = {F3_BU, 32'h101, 5'd12, 32'h80FF1234, 32'h00000012};
                4: v = {F3_W,  32'h104, 5'd31, 32'h89ABCDEF, 32'h89ABCDEF};
                default: v = {F3_H, 32'h100, 5'd1, 32'h0000F00D, 32'hFFFFF00D};
            endcase
            exp_mem_q.push_back({v.a & 32'hFFFFFFFC, 1'b0, 4'b0, 32'h0});
            exp_wb_q.push_back({1'b1, v.rd, v.exp});
            send(1'b0, v.f3, v.a, 32'h0, v.rd);
            serve_mem(got, w);
            e = exp_mem_q.pop_front();
            n_checks++;
            if (w !== 0 || got !== e) begin
                n_fail++;
                $display("FAIL ld%0d_req: got %h want %h", i, got, e);
            end
            mem_bus.mem_rsp_valid = 1'b1;
            mem_bus.mem_rdata     = v.rdata;
            @(negedge clk);
            mem_bus.mem_rsp_valid = 1'b0;
            mem_bus.mem_rdata     = 32'h0;
            wo = {wb_enable, wb_addr, wb_data};
            we = exp_wb_q.pop_front();
            n_checks++;
            if (wo !== we) begin
                n_fail++;
                $display("FAIL ld%0d_wb: got %h want %h", i, wo, we);
            end
            @(negedge clk);
            n_checks++;
            if ({wb_enable, req_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL ld%0d_wb_pulse: en/rdy %b%b want 01",
                         i, wb_enable, req_ready);
            end
        end
    endtask

    task automatic test_fault();
        send(1'b1, F3_H, 32'h101, 32'hFFFF, 5'd0);
        n_checks++;
        if ({fault, fault_addr, mem_bus.mem_req_valid, req_ready} !==
            {1'b1, 32'h101, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sh_misal: fault %b addr %h mv %b rdy %b",
                     fault, fault_addr, mem_bus.mem_req_valid, req_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({fault, fault_addr, mem_bus.mem_req_valid} !==
            {1'b0, 32'h101, 1'b0}) begin
            n_fail++;
            $display("FAIL fault_pulse: fault %b addr %h mv %b",
                     fault, fault_addr, mem_bus.mem_req_valid);
        end
        send(1'b0, 3'b011, 32'h400, 32'h0, 5'd4);
        n_checks++;
        if ({fault, fault_addr, mem_bus.mem_req_valid} !==
            {1'b1, 32'h400, 1'b0}) begin
            n_fail++;
            $display("FAIL ld_bad_f3: fault %b addr %h mv %b",
                     fault, fault_addr, mem_bus.mem_req_valid);
        end
        send(1'b0, F3_W, 32'h502, 32'h0, 5'd4);
        n_checks++;
        if ({fault, fault_addr, mem_bus.mem_req_valid} !==
            {1'b1, 32'h502, 1'b0}) begin
            n_fail++;
            $display("FAIL lw_misal: fault %b addr %h mv %b",
                     fault, fault_addr, mem_bus.mem_req_valid);
        end
    endtask

    task automatic test_stall_reset();
        mem_exp_t e;
        logic [141:0] obs;
        logic saw_wb;
        exp_mem_q.push_back({32'h300, 1'b0, 4'b0, 32'h0});
        send(1'b0, F3_W, 32'h300, 32'h0, 5'd9);
        e = exp_mem_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({req_ready, mem_bus.mem_req_valid, cur_mem()} !==
                {1'b0, 1'b1, e}) begin
                n_fail++;
                $display("FAIL stall%0d: rdy %b mv %b req %h want %h",
                         i, req_ready, mem_bus.mem_req_valid, cur_mem(), e);
            end
            @(negedge clk);
        end
        mem_bus.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_bus.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        obs = {req_ready, mem_bus.mem_req_valid, mem_bus.mem_addr,
               mem_bus.mem_we, mem_bus.mem_wstrb, mem_bus.mem_wdata,
               wb_enable, wb_addr, wb_data, fault, fault_addr};
        n_checks++;
        if (obs !== {1'b1, 141'h0}) begin
            n_fail++;
            $display("FAIL reset_in_wait: got %h", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rdata     = 32'hCAFEF00D;
        saw_wb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_bus.mem_rsp_valid = 1'b0;
            if (wb_enable) saw_wb = 1'b1;
        end
        n_checks++;
        if ({saw_wb, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL stale_rsp: wb %b rdy %b want 0 1", saw_wb, req_ready);
        end
    endtask

    task automatic test_rd0();
        mem_exp_t got, e;
        int w;
        exp_mem_q.push_back({32'h108, 1'b0, 4'b0, 32'h0});
        send(1'b0, F3_W, 32'h108, 32'h0, 5'd0);
        serve_mem(got, w);
        e = exp_mem_q.pop_front();
        n_checks++;
        if (w !== 0 || got !== e) begin
            n_fail++;
            $display("FAIL rd0_req: got %h want %h", got, e);
        end
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rdata     = 32'h11223344;
        @(negedge clk);
        mem_bus.mem_rsp_valid = 1'b0;
        n_checks++;
        if (wb_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL rd0_wb: wb_enable %b want 0", wb_enable);
        end
        @(negedge clk);
        n_checks++;
        if ({wb_enable, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rd0_done: en/rdy %b%b want 01", wb_enable, req_ready);
        end
    endtask

    initial begin
        rst_n                 = 1'b0;
        req_valid             = 1'b0;
        req_is_store          = 1'b0;
        req_funct3            = 3'b000;
        req_addr              = 32'h0;
        req_store_data        = 32'h0;
        req_rd                = 5'd0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rdata     = 32'h0;
        test_reset();
        test_sw();
        test_sub_word_stores();
        test_loads();
        test_fault();
        test_stall_reset();
        test_rd0();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) for the single-core pipeline.
- Accepts one memory op at a time from execute and runs a valid/ready handshake with data memory.
- For loads, aligns and extends the returned word, then drives the register file write port (write enable, address, data) for one cycle.
- Sits directly upstream of the register file write port.

Parameters:
- ADDR_WIDTH, default DATA_WIDTH (32), byte address width on request and memory sides.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute presents a memory op
- req_ready  out  1  unit can accept an op
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (size/sign)
- req_addr  in  ADDR_WIDTH  effective byte address
- req_store_data  in  DATA_WIDTH  rs2 value
- req_rd  in  REG_ADDR_BITS  load destination register
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_WIDTH  word-aligned address, [1:0] = 0
- mem_we  out  1  write request
- mem_wstrb  out  4  byte strobes
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_rsp_valid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read word
- wb_enable  out  1  register file write enable
- wb_addr  out  REG_ADDR_BITS  register file write address
- wb_data  out  DATA_WIDTH  register file write data
- fault  out  1  one-cycle pulse: misaligned or illegal op
- fault_addr  out  ADDR_WIDTH  faulting address, held until next fault

Behaviour:
- Reset:
  - State goes to IDLE.
  - req_ready = 1. All other outputs are 0, including fault_addr.
- States:
  - IDLE → REQ: accept on req_valid && req_ready, then latch all req_* fields.
  - REQ → (store) IDLE, or (load) WAIT: taken on mem_req_valid && mem_req_ready.
  - WAIT → WB: taken on mem_rsp_valid.
  - WB → IDLE: after exactly one cycle.
- req_ready = 1 only in IDLE.
- Legality is checked in the accept cycle:
  - Illegal funct3: load 011/110/111, or store with funct3 ≥ 011.
  - Misaligned: halfword with addr[0] ≠ 0, or word with addr[1:0] ≠ 0.
  - Either case: fault pulses 1 in the next cycle, fault_addr latches req_addr, state stays IDLE, and no memory request or writeback occurs.
- mem_req_valid is 1 throughout REQ. mem_addr, mem_we, mem_wstrb and mem_wdata are registered and stable until the handshake; valid never drops before ready.
- Store strobes:
  - SB: wstrb = 0001 << addr[1:0], byte replicated to all 4 lanes.
  - SH: wstrb = 0011 << addr[1:0], halfword replicated to both halves.
  - SW: wstrb = 1111.
- Loads:
  - mem_we = 0 and wstrb = 0000.
  - Lane = mem_rdata >> (8 × addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word unchanged.
- WB:
  - wb_data and wb_addr are valid for exactly one cycle.
  - wb_enable = 1 only if rd ≠ 0. rd = 0 loads still perform the memory read.
- Latency, with accept in cycle T:
  - mem_req_valid in T+1.
  - Load with zero-wait memory: response in T+2, wb_enable in T+3.
  - Store: complete on handshake; earliest next accept in T+2.
- mem_rsp_valid outside WAIT is ignored.
- mem_req_ready outside REQ is ignored.
- Reset mid-operation: returns to IDLE immediately. The outstanding response is dropped and no writeback is issued.

Decomposition:
- riscv_pkg:
  - lsu_state_e (IDLE, REQ, WAIT, WB).
  - funct3 localparams: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Reuses DATA_WIDTH and REG_ADDR_BITS.
- One combinational sub-module, lsu_load_align:
  - Inputs: mem_rdata, addr[1:0], funct3.
  - Output: aligned and extended wb_data.
- Store lane and strobe generation stays inline.

Test Plan:
1. SW addr 0x100, data 0xDEADBEEF, mem_req_ready = 1 → T+1: mem_addr 0x100, we = 1, wstrb 1111, wdata 0xDEADBEEF; no wb_enable; req_ready = 1 at T+2.
2. SB addr 0x203, data 0x000000A5 → mem_addr 0x200, wstrb 1000, wdata 0xA5A5A5A5.
3. LB addr 0x103, rd = 5, mem_rdata 0x80FF1234 → one-cycle wb_enable = 1, wb_addr 5, wb_data 0xFFFFFF80.
4. LHU addr 0x102, rd = 7, mem_rdata 0x80FF1234 → wb_data 0x000080FF. With LH instead → 0xFFFF80FF.
5. SH addr 0x101 → fault pulse for 1 cycle, fault_addr 0x101, mem_req_valid stays 0.
6. LW with mem_req_ready low for 3 cycles → mem_* outputs stable and req_ready = 0. Assert rst_n low during WAIT → all outputs 0; a later mem_rsp_valid causes no wb_enable. LW with rd = 0 → memory read issued, wb_enable stays 0.
